// File: rtl/reg_load_pkg.sv
// rtl/reg_load_pkg.sv - shared state type, beat one-hot codes and constants for reg_load_ctrl
package reg_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4
  } state_t;

  localparam int DATA_W_DEF = 8;

  localparam logic [3:0] T0_OH = 4'b0001;
  localparam logic [3:0] T1_OH = 4'b0010;
  localparam logic [3:0] T2_OH = 4'b0100;
  localparam logic [3:0] T3_OH = 4'b1000;

  localparam int STEP_SYNC_DEPTH = 2;

  function automatic logic [3:0] beat_oh(state_t s);
    logic [3:0] oh;
    case (s)
      ST_T0:   oh = T0_OH;
      ST_T1:   oh = T1_OH;
      ST_T2:   oh = T2_OH;
      ST_T3:   oh = T3_OH;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/step_pulse.sv
// rtl/step_pulse.sv - synchronises the raw STEP button and emits a one-cycle rising-edge pulse
module step_pulse
  import reg_load_pkg::*;
(
  input  logic CLK,
  input  logic CLR_N,
  input  logic STEP,
  output logic PULSE
);

  logic [STEP_SYNC_DEPTH-1:0] sync_q;
  logic                       prev_q;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STEP_SYNC_DEPTH-2:0], STEP};
      prev_q <= sync_q[STEP_SYNC_DEPTH-1];
    end
  end

  assign PULSE = sync_q[STEP_SYNC_DEPTH-1] & ~prev_q;

endmodule

// File: rtl/reg_load_ctrl.sv
// rtl/reg_load_ctrl.sv - four-beat bus transfer sequencer; REG_LOAD_XFER_CNT_EN adds the XFER_CNT transfer counter
module reg_load_ctrl
  import reg_load_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                       CLK,
  input  logic                       CLR_N,
  input  logic                       START,
  input  logic                       SRC_IS_SW,
  input  logic [2:0]                 SRC_SEL,
  input  logic [2:0]                 DST_SEL,
  input  logic [DATA_W-1:0]          SW_DATA,
  input  logic [NUM_REGS*DATA_W-1:0] REG_Q,
  input  logic                       STEP_MODE,
  input  logic                       STEP,
  output logic [DATA_W-1:0]          BUS_OUT,
  output logic [NUM_REGS-1:0]        LD_N,
  output logic [3:0]                 T,
  output logic                       BUSY,
  output logic                       DONE
`ifdef REG_LOAD_XFER_CNT_EN
  ,
  output logic [7:0]                 XFER_CNT
`endif
);

  state_t              state_q, state_nxt;
  logic                src_is_sw_q;
  logic [2:0]          src_sel_q;
  logic [2:0]          dst_sel_q;
  logic                step_pls;
  logic                adv;
  logic [DATA_W-1:0]   bus_nxt;
  logic [NUM_REGS-1:0] ld_n_nxt;
  logic                done_nxt;
  logic                capture;

  // Out-of-range selects match no register, so they yield a zero bus / no strobe.
  function automatic logic [DATA_W-1:0] src_value(logic is_sw, logic [2:0] sel,
                                                  logic [DATA_W-1:0] sw,
                                                  logic [NUM_REGS*DATA_W-1:0] q);
    logic [DATA_W-1:0] v;
    v = '0;
    if (is_sw) begin
      v = sw;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sel == 3'(i)) v = q[i*DATA_W +: DATA_W];
      end
    end
    return v;
  endfunction

  function automatic logic [NUM_REGS-1:0] ld_decode(logic [2:0] dst);
    logic [NUM_REGS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dst == 3'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  step_pulse u_step_pulse (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .STEP  (STEP),
    .PULSE (step_pls)
  );

  assign adv = STEP_MODE ? step_pls : 1'b1;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    capture   = 1'b0;
    bus_nxt   = BUS_OUT;
    ld_n_nxt  = '1;
    done_nxt  = 1'b0;
    case (state_q)
      ST_IDLE: if (START && adv) begin
        state_nxt = ST_T0;
        capture   = 1'b1;
      end
      ST_T0:   if (adv) state_nxt = ST_T1;
      ST_T1:   if (adv) state_nxt = ST_T2;
      ST_T2:   if (adv) state_nxt = ST_T3;
      ST_T3:   if (adv) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (capture) begin
      bus_nxt = src_value(SRC_IS_SW, SRC_SEL, SW_DATA, REG_Q);
    end else if (state_q == ST_T0 || state_q == ST_T1 || state_q == ST_T2) begin
      bus_nxt = src_value(src_is_sw_q, src_sel_q, SW_DATA, REG_Q);
    end

    // Strobe only on the T1->T2 edge so a long manual T2 beat still gives one clock.
    if (state_q == ST_T1 && state_nxt == ST_T2) ld_n_nxt = ld_decode(dst_sel_q);
    if (state_q == ST_T2 && state_nxt == ST_T3) done_nxt = 1'b1;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      src_is_sw_q <= 1'b0;
      src_sel_q   <= '0;
      dst_sel_q   <= '0;
      BUS_OUT     <= '0;
      LD_N        <= '1;
      T           <= 4'b0000;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      if (capture) begin
        src_is_sw_q <= SRC_IS_SW;
        src_sel_q   <= SRC_SEL;
        dst_sel_q   <= DST_SEL;
      end
      BUS_OUT <= bus_nxt;
      LD_N    <= ld_n_nxt;
      T       <= beat_oh(state_nxt);
      BUSY    <= (state_nxt != ST_IDLE);
      DONE    <= done_nxt;
    end
  end

`ifdef REG_LOAD_XFER_CNT_EN
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)    XFER_CNT <= 8'd0;
    else if (DONE) XFER_CNT <= XFER_CNT + 8'd1;
  end
`endif

endmodule

// File: tb/tb_reg_load_ctrl.sv
// tb/tb_reg_load_ctrl.sv - scoreboard bench for reg_load_ctrl with a transfer-level reference model
module tb_reg_load_ctrl;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 8;

  logic                       CLK = 1'b0;
  logic                       CLR_N = 1'b1;
  logic                       START = 1'b0;
  logic                       SRC_IS_SW = 1'b0;
  logic [2:0]                 SRC_SEL = '0;
  logic [2:0]                 DST_SEL = '0;
  logic [DATA_W-1:0]          SW_DATA = '0;
  logic [NUM_REGS*DATA_W-1:0] REG_Q;
  logic                       STEP_MODE = 1'b0;
  logic                       STEP = 1'b0;
  logic [DATA_W-1:0]          BUS_OUT;
  logic [NUM_REGS-1:0]        LD_N;
  logic [3:0]                 T;
  logic                       BUSY;
  logic                       DONE;
`ifdef REG_LOAD_XFER_CNT_EN
  logic [7:0]                 XFER_CNT;
`endif

  reg_load_ctrl #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) dut (
    .CLK       (CLK),
    .CLR_N     (CLR_N),
    .START     (START),
    .SRC_IS_SW (SRC_IS_SW),
    .SRC_SEL   (SRC_SEL),
    .DST_SEL   (DST_SEL),
    .SW_DATA   (SW_DATA),
    .REG_Q     (REG_Q),
    .STEP_MODE (STEP_MODE),
    .STEP      (STEP),
    .BUS_OUT   (BUS_OUT),
    .LD_N      (LD_N),
    .T         (T),
    .BUSY      (BUSY),
    .DONE      (DONE)
`ifdef REG_LOAD_XFER_CNT_EN
    ,
    .XFER_CNT  (XFER_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [7:0] phys [NUM_REGS];
  logic [7:0] mreg [NUM_REGS];

  typedef struct {
    bit         has_load;
    int         dst;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // 74LS377-style destination registers
  always @(posedge CLK) begin
    for (int i = 0; i < NUM_REGS; i++)
      if (CLR_N && LD_N[i] === 1'b0) phys[i] <= BUS_OUT;
  end

  always_comb begin
    REG_Q = '0;
    for (int i = 0; i < NUM_REGS; i++) REG_Q[i*DATA_W +: DATA_W] = phys[i];
  end

  // Monitor: pops one expected transfer per DONE
  int         ld_cnt = 0;
  logic [3:0] ld_val;
  logic [7:0] ld_bus;
  logic [3:0] prev_t = 4'b0000;

  always @(negedge CLK) begin
    exp_t       e;
    logic [3:0] nxt_t;
    logic [3:0] m;
    logic [3:0] exp_ld;
    if (!CLR_N) begin
      ld_cnt = 0;
      prev_t = 4'b0000;
    end else begin
      if (LD_N !== 4'hF) begin
        ld_cnt++;
        ld_val = LD_N;
        ld_bus = BUS_OUT;
      end
      if (T !== prev_t) begin
        nxt_t = (prev_t == 4'b0000) ? 4'b0001 : (prev_t << 1);
        if (T == 4'b0000) chk("beat_exit", {28'b0, prev_t}, 32'h8);
        else              chk("beat_order", {28'b0, T}, {28'b0, nxt_t});
        chk("busy_vs_t", {31'b0, BUSY}, {31'b0, (T != 4'b0000)});
        prev_t = T;
      end
      if (DONE === 1'b1) begin
        chk("done_in_t3", {28'b0, T}, 32'h8);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=DONE required=no DONE");
        end else begin
          e = exp_q.pop_front();
          chk("ld_count", ld_cnt, e.has_load ? 1 : 0);
          if (e.has_load) begin
            m      = 4'b0001 << e.dst;
            exp_ld = ~m;
            chk("ld_n_bits", {28'b0, ld_val}, {28'b0, exp_ld});
            chk("bus_at_load", {24'b0, ld_bus}, {24'b0, e.data});
          end
        end
        ld_cnt = 0;
      end
    end
  end

  task automatic push_exp(bit sw, int src, int dst, logic [7:0] swd);
    exp_t e;
    e.data     = sw ? swd : ((src < NUM_REGS) ? mreg[src] : 8'h00);
    e.has_load = (dst < NUM_REGS);
    e.dst      = dst;
    exp_q.push_back(e);
    if (e.has_load) mreg[dst] = e.data;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (BUSY === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic do_xfer(bit sw, int src, int dst, logic [7:0] swd, bit poke_busy, bit mutate);
    push_exp(sw, src, dst, swd);
    @(posedge CLK); #1;
    SRC_IS_SW = sw;
    SRC_SEL   = 3'(src);
    DST_SEL   = 3'(dst);
    SW_DATA   = swd;
    START     = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    if (mutate) begin
      SRC_SEL   = 3'(src + 1);
      DST_SEL   = 3'(dst + 1);
      SRC_IS_SW = ~sw;
    end
    if (poke_busy) START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] keep;
    logic [3:0] exp_t_oh;

    phys[0] = 8'h11; phys[1] = 8'h3C; phys[2] = 8'h5A; phys[3] = 8'h77;
    for (int i = 0; i < NUM_REGS; i++) mreg[i] = phys[i];

    #2 CLR_N = 1'b0;
    #1;
    chk("rst_bus",  {24'b0, BUS_OUT}, 32'h0);
    chk("rst_ld_n", {28'b0, LD_N}, 32'hF);
    chk("rst_t",    {28'b0, T}, 32'h0);
    chk("rst_busy", {31'b0, BUSY}, 32'h0);
    chk("rst_done", {31'b0, DONE}, 32'h0);
    repeat (2) @(posedge CLK);
    #1 CLR_N = 1'b1;

    // Run mode, switches -> reg2, cycle-exact beat walk
    push_exp(1'b1, 0, 2, 8'hA5);
    @(posedge CLK); #1;
    SRC_IS_SW = 1'b1; DST_SEL = 3'd2; SW_DATA = 8'hA5; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("run_t0", {28'b0, T}, 32'h1);
    @(posedge CLK); #1;
    chk("run_t1", {28'b0, T}, 32'h2);
    @(posedge CLK); #1;
    chk("run_t2", {28'b0, T}, 32'h4);
    chk("run_ld_n", {28'b0, LD_N}, 32'hB);
    chk("run_bus", {24'b0, BUS_OUT}, 32'hA5);
    @(posedge CLK); #1;
    chk("run_t3", {28'b0, T}, 32'h8);
    chk("run_done", {31'b0, DONE}, 32'h1);
    chk("run_ld_off", {28'b0, LD_N}, 32'hF);
    @(posedge CLK); #1;
    chk("run_idle", {28'b0, T}, 32'h0);
    chk("run_done_off", {31'b0, DONE}, 32'h0);
    chk("run_reg2", {24'b0, phys[2]}, 32'hA5);

    // Register-to-register with selects disturbed during T1
    do_xfer(1'b0, 1, 3, 8'h00, 1'b0, 1'b1);
    chk("r2r_reg3", {24'b0, phys[3]}, 32'h3C);

    // Edge cases
    do_xfer(1'b0, 0, 5, 8'h00, 1'b0, 1'b0);
    do_xfer(1'b1, 0, 1, 8'hC3, 1'b1, 1'b0);
    keep = phys[0];
    do_xfer(1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
    chk("self_reload", {24'b0, phys[0]}, {24'b0, keep});
    do_xfer(1'b0, 6, 2, 8'h00, 1'b0, 1'b0);

    // Step mode: five presses, one beat each
    STEP_MODE = 1'b1;
    push_exp(1'b0, 3, 1, 8'h00);
    @(posedge CLK); #1;
    SRC_IS_SW = 1'b0; SRC_SEL = 3'd3; DST_SEL = 3'd1; START = 1'b1;
    for (int p = 1; p <= 5; p++) begin
      #3 STEP = 1'b1;
      repeat (3) @(posedge CLK);
      #3 STEP = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      if (p == 1) START = 1'b0;
      exp_t_oh = (p < 5) ? (4'b0001 << (p - 1)) : 4'b0000;
      chk("step_beat", {28'b0, T}, {28'b0, exp_t_oh});
    end
    STEP_MODE = 1'b0;

    // Reset during T2 while the strobe is low
    @(posedge CLK); #1;
    SRC_IS_SW = 1'b1; DST_SEL = 3'd1; SW_DATA = 8'hE7; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("abort_ld_armed", {28'b0, LD_N}, 32'hD);
    #2 CLR_N = 1'b0;
    #1;
    chk("abort_ld_n", {28'b0, LD_N}, 32'hF);
    chk("abort_t", {28'b0, T}, 32'h0);
    chk("abort_bus", {24'b0, BUS_OUT}, 32'h0);
    repeat (2) @(posedge CLK);
    #1 CLR_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_no_load", {24'b0, phys[1]}, {24'b0, mreg[1]});

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      do_xfer(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 5),
              8'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

`ifdef REG_LOAD_XFER_CNT_EN
    @(posedge CLK); #1 CLR_N = 1'b0;
    @(posedge CLK); #1 CLR_N = 1'b1;
    for (int n = 0; n < 257; n++) begin
      do_xfer(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 5),
              8'($urandom), 1'b0, 1'b0);
    end
    chk("xfer_cnt_wrap", {24'b0, XFER_CNT}, 32'h1);
`endif

    repeat (4) @(posedge CLK);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    for (int i = 0; i < NUM_REGS; i++) chk("final_reg", {24'b0, phys[i]}, {24'b0, mreg[i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_load_ctrl.md
Name: reg_load_ctrl

Overview:
- Bus-transfer sequencer that sits directly upstream of the octal enable registers (the 74LS377-style cells) in the model computer.
- Drives the shared 8-bit data bus from a selected source.
- Generates each destination register's active-low load enable on a four-beat timing cycle (T0–T3).
- Supports free-run transfers and single-step (manual clock-beat) operation for lab demonstration.

Parameters:
- NUM_REGS, 4, number of destination/source registers served (2..8).
- DATA_W, 8, bus and register data width.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- CLR_N  in  1  asynchronous active-low reset.
- START  in  1  request one transfer; sampled in IDLE only.
- SRC_IS_SW  in  1  1 = bus source is SW_DATA, 0 = register selected by SRC_SEL.
- SRC_SEL  in  3  source register index (valid 0..NUM_REGS-1).
- DST_SEL  in  3  destination register index (valid 0..NUM_REGS-1).
- SW_DATA  in  DATA_W  front-panel switch data.
- REG_Q  in  NUM_REGS*DATA_W  concatenated register outputs; register i occupies bits [i*DATA_W +: DATA_W].
- STEP_MODE  in  1  1 = beats advance only on STEP pulses.
- STEP  in  1  raw manual step button, asynchronous to CLK.
- BUS_OUT  out  DATA_W  data bus, wired to every register's D input.
- LD_N  out  NUM_REGS  per-register active-low load enable, wired to the registers' EN.
- T  out  4  one-hot beat indicator, T[0]..T[3].
- BUSY  out  1  high from T0 through T3.
- DONE  out  1  one-cycle pulse in T3.

Behaviour:
- Reset (CLR_N low, asynchronous): state IDLE; BUS_OUT=0; LD_N all ones; T=0; BUSY=0; DONE=0; step synchroniser cleared. An in-flight transfer is abandoned with no load strobe.
- States: IDLE, T0, T1, T2, T3. All outputs are registered.
- Advance condition ADV: 1 every clock when STEP_MODE=0; in step mode, the one-cycle synchronised rising-edge pulse of STEP.
- IDLE → T0 on START=1 AND ADV. In step mode, START must be held until a step pulse arrives.
- On entry to T0, capture SRC_IS_SW, SRC_SEL and DST_SEL into internal registers. Input changes after T0 have no effect on the transfer.
- T0 → T1 → T2 → T3 → IDLE, each transition on ADV. State holds otherwise.
- BUS_OUT: loaded at T0 entry from the selected source. Re-sampled from the latched source every cycle through T2, so it is stable at the load edge. Retains its last value in IDLE.
- LD_N[dst]: low for exactly one clock, in the cycle after T2 entry. The register captures on the rising edge that ends that cycle. In step mode it is still exactly one clock, never held for the whole beat.
  - All other LD_N bits stay high throughout the transfer.
- T[k]=1 only while in beat k. BUSY = (state != IDLE). DONE=1 in the first cycle of T3 only.
- Index out of range (SRC_SEL or DST_SEL ≥ NUM_REGS): the transfer sequences normally, but BUS_OUT=0 for a bad source and no LD_N is asserted for a bad destination.
- Source equal to destination is legal: the register reloads its own value.
- START while BUSY is ignored, not queued.
- Toggling STEP_MODE mid-transfer takes effect on the next cycle.
- Step button glitches are the caller's concern; synchronisation uses two flops, and edge detect is the third.

Optional Feature:
- Macro: REG_LOAD_XFER_CNT_EN.
- Defined: adds output XFER_CNT [7:0]. It is reset to 0, increments by 1 in the DONE cycle, and wraps 255 → 0. Transfers to an out-of-range destination are also counted.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package reg_load_pkg holds:
  - the state enum (IDLE, T0..T3);
  - DATA_W default;
  - the beat one-hot constants T0_OH..T3_OH;
  - the step synchroniser depth constant (2).
- One sub-module, step_pulse: 2-flop synchroniser plus rising-edge detector on STEP, with asynchronous clear on CLR_N, producing a one-cycle pulse.

Test Plan:
- Run mode: SW_DATA=0xA5, SRC_IS_SW=1, DST_SEL=2, one-cycle START.
  - Required: T walks 0001, 0010, 0100, 1000 on consecutive clocks.
  - LD_N goes 1011 for exactly one cycle after T2 entry; BUS_OUT=0xA5 at that edge.
  - DONE pulses once and a model register 2 holds 0xA5.
- Register-to-register: REG_Q reg1=0x3C, SRC_SEL=1, DST_SEL=3.
  - Change SRC_SEL to 0 during T1.
  - Required: BUS_OUT remains 0x3C and register 3 ends holding 0x3C.
- Step mode: STEP_MODE=1, START held, STEP pressed 5 times with 10-cycle gaps.
  - Required: exactly one beat per press; LD_N low for exactly one clock; IDLE after the 5th press.
- Reset mid-op: assert CLR_N=0 during T2.
  - Required: LD_N returns to all ones asynchronously, T=0, BUS_OUT=0, and no register load occurs.
- Edge cases:
  - DST_SEL=5 with NUM_REGS=4: full beat cycle and DONE occur, but LD_N stays all ones.
  - START asserted while BUSY: ignored, only one DONE.
  - SRC_SEL=DST_SEL=0: register 0 value unchanged.
- With REG_LOAD_XFER_CNT_EN: 257 back-to-back transfers.
  - Required: XFER_CNT reads 1 after the last transfer (wrapped).
